// File: rtl/triad_decoder_ly.sv
// Per-layer comparator triad decoder.
// Each distrip line carries a serial triad: a start bit, a strip bit and a
// left/right bit. A completed triad becomes a one-clock pulse on one of the
// four half-strips of that distrip, one clock after the last bit. A per-clock
// hit count and a saturating layer monitor counter are also produced.
module triad_decoder_ly #(
  parameter int NCH         = 56,
  parameter int NCFEB       = 7,
  parameter int CH_PER_CFEB = 8,
  parameter int NHS         = 224
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             triad_clr,
  input  logic [NCFEB-1:0] cfeb_en,
  input  logic [NCH-1:0]   triad_in,
  input  logic             count_clr,
  output logic [NHS-1:0]   hs_out,
  output logic [5:0]       nhits,
  output logic [15:0]      triad_count
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] GOT_START = 2'd1;
  localparam logic [1:0] GOT_STRIP = 2'd2;

  logic [1:0]     state_p0  [NCH];
  logic [1:0]     state_nxt [NCH];
  logic [NCH-1:0] strip_p0;
  logic [NCH-1:0] ch_en;
  logic [NCH-1:0] done_p0;
  logic [NHS-1:0] hs_p0;

  // Number of channels that completed a triad this clock.
  function automatic logic [5:0] popcount(input logic [NCH-1:0] d);
    logic [5:0] cnt;
    cnt = 6'd0;
    for (int i = 0; i < NCH; i++) begin
      cnt = cnt + 6'(d[i]);
    end
    return cnt;
  endfunction

  // Accumulate with saturation at full scale instead of wrapping.
  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [5:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {11'd0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  // Expand the per-CFEB enable onto its channels.
  always_comb begin
    for (int ch = 0; ch < NCH; ch++) begin
      ch_en[ch] = cfeb_en[ch / CH_PER_CFEB];
    end
  end

  // Channel state registers; a disabled or aborted channel falls back to IDLE.
  always_ff @(posedge clock) begin
    for (int ch = 0; ch < NCH; ch++) begin
      if (reset) state_p0[ch] <= IDLE;
      else       state_p0[ch] <= state_nxt[ch];
    end
  end

  // Strip bit capture; only consumed in GOT_STRIP, so no reset needed.
  always_ff @(posedge clock) begin
    for (int ch = 0; ch < NCH; ch++) begin
      if (state_p0[ch] == GOT_START) strip_p0[ch] <= triad_in[ch];
    end
  end

  // Next state: bits after the start are always data, never a restart.
  always_comb begin
    for (int ch = 0; ch < NCH; ch++) begin
      state_nxt[ch] = state_p0[ch];
      if (triad_clr || !ch_en[ch]) begin
        state_nxt[ch] = IDLE;
      end else begin
        case (state_p0[ch])
          IDLE:      state_nxt[ch] = triad_in[ch] ? GOT_START : IDLE;
          GOT_START: state_nxt[ch] = GOT_STRIP;
          GOT_STRIP: state_nxt[ch] = IDLE;
          default:   state_nxt[ch] = IDLE;
        endcase
      end
    end
  end

  // Hit decode: last bit arriving selects half-strip 2*s+l of the distrip.
  always_comb begin
    for (int ch = 0; ch < NCH; ch++) begin
      done_p0[ch]        = (state_p0[ch] == GOT_STRIP) && ch_en[ch] && !triad_clr;
      hs_p0[4*ch +: 4]   = done_p0[ch] ? (4'b0001 << {strip_p0[ch], triad_in[ch]}) : 4'b0000;
    end
  end

  // ---- output register stage: pulses and hit count aligned ----
  always_ff @(posedge clock) begin
    if (reset) begin
      hs_out <= '0;
      nhits  <= 6'd0;
    end else begin
      hs_out <= hs_p0;
      nhits  <= popcount(done_p0);
    end
  end

  // Monitor counter accumulates the registered hit count.
  always_ff @(posedge clock) begin
    if (reset || count_clr) triad_count <= 16'd0;
    else                    triad_count <= sat_add(triad_count, nhits);
  end

endmodule

// File: tb/tb_triad_decoder_ly.sv
// Directed bench for triad_decoder_ly: single, back-to-back, all-channel,
// abort, CFEB enable and counter saturation/clear scenarios.
module tb_triad_decoder_ly;

  logic         clock = 1'b0;
  logic         reset;
  logic         triad_clr;
  logic [6:0]   cfeb_en;
  logic [55:0]  triad_in;
  logic         count_clr;
  logic [223:0] hs_out;
  logic [5:0]   nhits;
  logic [15:0]  triad_count;

  int vectors     = 0;
  int miscompares = 0;

  triad_decoder_ly dut (
    .clock       (clock),
    .reset       (reset),
    .triad_clr   (triad_clr),
    .cfeb_en     (cfeb_en),
    .triad_in    (triad_in),
    .count_clr   (count_clr),
    .hs_out      (hs_out),
    .nhits       (nhits),
    .triad_count (triad_count)
  );

  always #5 clock = ~clock;

  // Apply one input vector across a rising edge; outputs are then settled.
  task automatic step(input logic [55:0] tin);
    triad_in = tin;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [223:0] got, input logic [223:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_count();
    count_clr = 1'b1;
    step('0);
    count_clr = 1'b0;
  endtask

  logic [223:0] all_hs3;
  logic [55:0]  ones;
  int           k;

  initial begin
    reset     = 1'b1;
    triad_clr = 1'b0;
    cfeb_en   = 7'h7F;
    triad_in  = '0;
    count_clr = 1'b0;
    ones      = '1;
    all_hs3   = '0;
    for (int ch = 0; ch < 56; ch++) all_hs3[4*ch+3] = 1'b1;

    step('0);
    step('0);
    chk("reset_hs", hs_out, '0);
    chk("reset_nhits", 224'(nhits), '0);
    chk("reset_count", 224'(triad_count), '0);
    reset = 1'b0;

    // Test 1: channel 5, s=1 l=0 -> half-strip 22
    step(56'(1) << 5);
    step(56'(1) << 5);
    chk("t1_no_early", hs_out, '0);
    step('0);
    chk("t1_hs", hs_out, 224'(1) << 22);
    chk("t1_nhits", 224'(nhits), 224'd1);
    step('0);
    chk("t1_hs_oneclk", hs_out, '0);
    chk("t1_count", 224'(triad_count), 224'd1);

    // Test 2: channel 0 back-to-back (s=0,l=1) then (s=1,l=0)
    clear_count();
    chk("t2_clr", 224'(triad_count), '0);
    step(56'd1);
    step(56'd0);
    step(56'd1);
    chk("t2_hs_a", hs_out, 224'(1) << 1);
    step(56'd1);
    chk("t2_gap", hs_out, '0);
    step(56'd1);
    step(56'd0);
    chk("t2_hs_b", hs_out, 224'(1) << 2);
    step('0);
    step('0);
    chk("t2_count", 224'(triad_count), 224'd2);

    // Test 3: all channels 1,1,1 at once
    clear_count();
    step(ones);
    step(ones);
    step(ones);
    chk("t3_hs", hs_out, all_hs3);
    chk("t3_nhits", 224'(nhits), 224'd56);
    step('0);
    step('0);
    chk("t3_count", 224'(triad_count), 224'd56);

    // Test 4: channel 9 aborted by triad_clr, then a fresh triad
    step(56'(1) << 9);
    triad_clr = 1'b1;
    step(56'(1) << 9);
    triad_clr = 1'b0;
    chk("t4_abort", hs_out, '0);
    step(56'(1) << 9);
    chk("t4_t2", hs_out, '0);
    step('0);
    chk("t4_t3", hs_out, '0);
    step('0);
    chk("t4_hs", hs_out, 224'(1) << 36);

    // Test 5: CFEB 0 disabled; channel 3 silent, channel 8 decodes
    cfeb_en = 7'b1111110;
    step((56'(1) << 3) | (56'(1) << 8));
    step((56'(1) << 3) | (56'(1) << 8));
    step('0);
    chk("t5_ch8_only", hs_out, 224'(1) << 34);
    step(56'(1) << 8);
    step(56'(1) << 8);
    cfeb_en = 7'b1111100;
    step(56'(1) << 8);
    chk("t5_drop", hs_out, '0);
    chk("t5_drop_nhits", 224'(nhits), '0);
    cfeb_en = 7'b1111111;
    step('0);
    chk("t5_reenable", hs_out, '0);

    // Test 6: saturate the counter with sustained full-layer hits
    clear_count();
    k = 0;
    while (triad_count !== 16'hFFFF && k < 4000) begin
      step(ones);
      k++;
    end
    chk("t6_reach_sat", 224'(triad_count), 224'hFFFF);
    for (int i = 0; i < 6; i++) step(ones);
    chk("t6_hold_sat", 224'(triad_count), 224'hFFFF);
    k = 0;
    while (nhits !== 6'd56 && k < 5) begin
      step(ones);
      k++;
    end
    chk("t6_hit_seen", 224'(nhits), 224'd56);
    count_clr = 1'b1;
    step(ones);
    count_clr = 1'b0;
    chk("t6_clr_with_hit", 224'(triad_count), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
